// File: rtl/image_unpack_if.sv
// rtl/image_unpack_if.sv - receive-word and pixel stream interfaces for image_unpack

// UDP receive word stream: the eth_udp_loop side drives (master), the unpacker listens (slave).
interface image_unpack_rec_if;
  logic        rec_en;
  logic [31:0] rec_data;
  logic        rec_pkt_done;

  modport master (output rec_en, rec_data, rec_pkt_done);
  modport slave  (input  rec_en, rec_data, rec_pkt_done);
endinterface

// RGB565 pixel stream with line/frame markers: the unpacker drives (master), the sink accepts (slave).
interface image_unpack_pix_if;
  logic        pix_valid;
  logic        pix_ready;
  logic [15:0] pix_data;
  logic        pix_sof;
  logic        pix_eol;
  logic        pix_eof;

  modport master (output pix_valid, pix_data, pix_sof, pix_eol, pix_eof, input pix_ready);
  modport slave  (input  pix_valid, pix_data, pix_sof, pix_eol, pix_eof, output pix_ready);
endinterface

// File: rtl/image_unpack.sv
// rtl/image_unpack.sv - UDP line packets back to an RGB565 pixel stream with sof/eol/eof markers
module image_unpack #(
  parameter int         H_PIXEL    = 1920,
  parameter int         V_PIXEL    = 1080,
  parameter logic [7:0] HDR_TAG    = 8'hA5,
  parameter int         FIFO_DEPTH = 16
) (
  input  logic               sys_clk,
  input  logic               sys_rst,
  image_unpack_rec_if.slave  rec,
  image_unpack_pix_if.master pix,
  output logic [15:0]        frame_cnt,
  output logic [15:0]        err_cnt,
  output logic               fifo_ovf
);

  localparam int          AW        = $clog2(FIFO_DEPTH);
  localparam logic [15:0] LAST_WORD = 16'(H_PIXEL / 2 - 1);
  localparam logic [15:0] LAST_LINE = 16'(V_PIXEL - 1);
  localparam logic [15:0] NUM_LINES = 16'(V_PIXEL);
  localparam logic [AW:0] PTR_ONE   = (AW + 1)'(1);

  typedef enum logic [1:0] {IDLE, PAYLOAD, DROP} state_t;

  state_t      state;
  state_t      state_next;

  // Packet context
  logic        in_frame;
  logic        sof_pend;
  logic        line_ok;
  logic [15:0] cur_line;
  logic [15:0] exp_line;
  logic [15:0] wcnt;

  // Header fields
  logic [7:0]  hdr_tag;
  logic        hdr_sof;
  logic [15:0] hdr_line;
  logic        hdr_ok;
  logic        unused_flags;

  // Payload word tagging
  logic        first_sof;
  logic        last_word;
  logic        line_ok_after;

  // Parser decisions for this cycle
  logic        hdr_accept;
  logic        set_in_frame;
  logic        clr_in_frame;
  logic        err_inc;
  logic        frame_inc;
  logic        ovf_set;
  logic        wcnt_inc;
  logic        line_done_set;
  logic        line_commit;

  // Word FIFO: {data[31:0], sof, eol, eof}
  logic [34:0] mem [FIFO_DEPTH];
  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  logic        fifo_full;
  logic        fifo_empty;
  logic        push;
  logic        pop;
  logic [34:0] push_word;
  logic [34:0] fifo_rdata;

  // Two-pixel holding register
  logic [31:0] hold_data;
  logic        hold_sof;
  logic        hold_eol;
  logic        hold_eof;
  logic        hold_valid;
  logic        hold_phase;

  assign hdr_tag      = rec.rec_data[31:24];
  assign hdr_sof      = rec.rec_data[16];
  assign hdr_line     = rec.rec_data[15:0];
  assign unused_flags = ^rec.rec_data[23:17];

  assign hdr_ok = (hdr_tag == HDR_TAG) && (hdr_line < NUM_LINES) &&
                  ((hdr_sof && (hdr_line == 16'd0)) ||
                   (!hdr_sof && in_frame && (hdr_line == exp_line)));

  assign first_sof = sof_pend && (wcnt == 16'd0);
  assign last_word = (wcnt == LAST_WORD);

  // line_ok is only ever set inside DROP after the last payload word, so a stale value cannot leak
  assign line_ok_after = line_done_set || line_ok;

  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign fifo_rdata = mem[rd_ptr[AW-1:0]];

  // Refill the holding register when empty or while its second pixel is being accepted
  assign pop = !fifo_empty && (!hold_valid || (hold_phase && pix.pix_ready));

  // Parser state register
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) state <= IDLE;
    else         state <= state_next;
  end

  // Parser next-state and per-cycle actions; the word is handled first, then any packet end
  always_comb begin
    state_next    = state;
    push          = 1'b0;
    push_word     = '0;
    hdr_accept    = 1'b0;
    set_in_frame  = 1'b0;
    clr_in_frame  = 1'b0;
    err_inc       = 1'b0;
    frame_inc     = 1'b0;
    ovf_set       = 1'b0;
    wcnt_inc      = 1'b0;
    line_done_set = 1'b0;
    line_commit   = 1'b0;

    case (state)
      IDLE: begin
        if (rec.rec_en) begin
          if (hdr_ok) begin
            state_next   = PAYLOAD;
            hdr_accept   = 1'b1;
            set_in_frame = hdr_sof;
          end else begin
            state_next   = DROP;
            err_inc      = 1'b1;
            clr_in_frame = 1'b1;
          end
        end
      end
      PAYLOAD: begin
        if (rec.rec_en) begin
          if (fifo_full && !pop) begin
            // Lost word: the line is damaged, so abandon the rest of the packet
            state_next   = DROP;
            ovf_set      = 1'b1;
            err_inc      = 1'b1;
            clr_in_frame = 1'b1;
          end else begin
            push      = 1'b1;
            push_word = {rec.rec_data, first_sof, last_word,
                         last_word && (cur_line == LAST_LINE)};
            wcnt_inc  = 1'b1;
            if (last_word) begin
              state_next    = DROP;
              line_done_set = 1'b1;
            end
          end
        end
      end
      DROP: begin
        state_next = DROP;
      end
      default: begin
        state_next = IDLE;
      end
    endcase

    if (rec.rec_pkt_done) begin
      if (state_next == PAYLOAD) begin
        // Packet ended before the line was complete
        err_inc      = 1'b1;
        clr_in_frame = 1'b1;
      end else if (line_ok_after) begin
        line_commit = 1'b1;
        if (cur_line == LAST_LINE) begin
          frame_inc    = 1'b1;
          clr_in_frame = 1'b1;
        end
      end
      state_next = IDLE;
    end
  end

  // Packet context, line tracking and status counters
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      in_frame  <= 1'b0;
      sof_pend  <= 1'b0;
      line_ok   <= 1'b0;
      cur_line  <= '0;
      exp_line  <= '0;
      wcnt      <= '0;
      frame_cnt <= '0;
      err_cnt   <= '0;
      fifo_ovf  <= 1'b0;
    end else begin
      if (hdr_accept) begin
        sof_pend <= hdr_sof;
        cur_line <= hdr_line;
        wcnt     <= '0;
      end else if (wcnt_inc) begin
        wcnt <= wcnt + 16'd1;
      end

      if (clr_in_frame)      in_frame <= 1'b0;
      else if (set_in_frame) in_frame <= 1'b1;

      if (rec.rec_pkt_done)   line_ok <= 1'b0;
      else if (line_done_set) line_ok <= 1'b1;

      if (line_commit) exp_line <= (cur_line == LAST_LINE) ? 16'd0 : cur_line + 16'd1;

      if (ovf_set) fifo_ovf <= 1'b1;

      if (err_inc && (err_cnt != 16'hFFFF))     err_cnt   <= err_cnt + 16'd1;
      if (frame_inc && (frame_cnt != 16'hFFFF)) frame_cnt <= frame_cnt + 16'd1;
    end
  end

  // FIFO pointers; one extra bit distinguishes full from empty
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  // FIFO storage; contents need no reset because the pointers gate every read
  always_ff @(posedge sys_clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= push_word;
  end

  // Holding register: load a word, present high pixel then low pixel, hold while stalled
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      hold_data  <= '0;
      hold_sof   <= 1'b0;
      hold_eol   <= 1'b0;
      hold_eof   <= 1'b0;
      hold_valid <= 1'b0;
      hold_phase <= 1'b0;
    end else if (pop) begin
      {hold_data, hold_sof, hold_eol, hold_eof} <= fifo_rdata;
      hold_valid <= 1'b1;
      hold_phase <= 1'b0;
    end else if (hold_valid && pix.pix_ready) begin
      if (!hold_phase) hold_phase <= 1'b1;
      else             hold_valid <= 1'b0;
    end
  end

  assign pix.pix_valid = hold_valid;
  assign pix.pix_data  = hold_phase ? hold_data[15:0] : hold_data[31:16];
  assign pix.pix_sof   = hold_valid && !hold_phase && hold_sof;
  assign pix.pix_eol   = hold_valid && hold_phase && hold_eol;
  assign pix.pix_eof   = hold_valid && hold_phase && hold_eof;

endmodule

// File: tb/tb_image_unpack.sv
// tb/tb_image_unpack.sv - scoreboard bench for image_unpack
module tb_image_unpack;

  logic sys_clk = 1'b0;
  logic sys_rst = 1'b1;
  always #5 sys_clk = ~sys_clk;

  image_unpack_rec_if rec_a ();
  image_unpack_pix_if pix_a ();
  image_unpack_rec_if rec_b ();
  image_unpack_pix_if pix_b ();

  logic [15:0] frame_cnt_a, err_cnt_a, frame_cnt_b, err_cnt_b;
  logic        fifo_ovf_a, fifo_ovf_b;

  image_unpack #(.H_PIXEL(8), .V_PIXEL(2), .HDR_TAG(8'hA5), .FIFO_DEPTH(16)) dut_a (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .rec(rec_a), .pix(pix_a),
    .frame_cnt(frame_cnt_a), .err_cnt(err_cnt_a), .fifo_ovf(fifo_ovf_a)
  );

  image_unpack #(.H_PIXEL(16), .V_PIXEL(2), .HDR_TAG(8'hA5), .FIFO_DEPTH(4)) dut_b (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .rec(rec_b), .pix(pix_b),
    .frame_cnt(frame_cnt_b), .err_cnt(err_cnt_b), .fifo_ovf(fifo_ovf_b)
  );

  int checks = 0;
  int errors = 0;

  // Expected pixels: {sof, eol, eof, data[15:0]}
  logic [18:0] exp_q_a [$];
  logic [18:0] exp_q_b [$];
  logic [18:0] got_a, want_a, got_b, want_b;

  logic [31:0] wd [0:7] = '{32'h11112222, 32'h33334444, 32'h55556666, 32'h77778888,
                            32'h9999AAAA, 32'hBBBBCCCC, 32'hDDDDEEEE, 32'h0F0F1E1E};

  // Monitor A: compare every accepted pixel against the scoreboard head
  always @(negedge sys_clk) begin
    if (pix_a.pix_valid && pix_a.pix_ready) begin
      checks++;
      got_a = {pix_a.pix_sof, pix_a.pix_eol, pix_a.pix_eof, pix_a.pix_data};
      if (exp_q_a.size() == 0) begin
        errors++;
        $display("FAIL pix_a_extra: got %h want no pixel", got_a);
      end else begin
        want_a = exp_q_a.pop_front();
        if (got_a !== want_a) begin
          errors++;
          $display("FAIL pix_a: got %h want %h", got_a, want_a);
        end
      end
    end
  end

  // Monitor B: same for the small-FIFO instance
  always @(negedge sys_clk) begin
    if (pix_b.pix_valid && pix_b.pix_ready) begin
      checks++;
      got_b = {pix_b.pix_sof, pix_b.pix_eol, pix_b.pix_eof, pix_b.pix_data};
      if (exp_q_b.size() == 0) begin
        errors++;
        $display("FAIL pix_b_extra: got %h want no pixel", got_b);
      end else begin
        want_b = exp_q_b.pop_front();
        if (got_b !== want_b) begin
          errors++;
          $display("FAIL pix_b: got %h want %h", got_b, want_b);
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, got, want);
    end
  endtask

  task automatic rx(input bit sel, input bit en, input logic [31:0] d, input bit done);
    if (sel) begin
      rec_b.rec_en = en; rec_b.rec_data = d; rec_b.rec_pkt_done = done;
    end else begin
      rec_a.rec_en = en; rec_a.rec_data = d; rec_a.rec_pkt_done = done;
    end
    @(posedge sys_clk);
    #1;
  endtask

  task automatic exp_word(input bit sel, input logic [31:0] d, input bit sof, input bit eol, input bit eof);
    if (sel) begin
      exp_q_b.push_back({sof, 1'b0, 1'b0, d[31:16]});
      exp_q_b.push_back({1'b0, eol, eof, d[15:0]});
    end else begin
      exp_q_a.push_back({sof, 1'b0, 1'b0, d[31:16]});
      exp_q_a.push_back({1'b0, eol, eof, d[15:0]});
    end
  endtask

  // Header plus n payload words from wd[]; done either rides on the last word or follows it
  task automatic send_line(input logic [31:0] hdr, input int n, input bit done_on_last);
    rx(1'b0, 1'b1, hdr, 1'b0);
    for (int i = 0; i < n; i++) rx(1'b0, 1'b1, wd[i], done_on_last && (i == n - 1));
    if (!done_on_last) rx(1'b0, 1'b0, 32'h0, 1'b1);
    rx(1'b0, 1'b0, 32'h0, 1'b0);
  endtask

  task automatic drain(input bit sel);
    for (int i = 0; i < 300; i++) begin
      if ((sel ? exp_q_b.size() : exp_q_a.size()) == 0) break;
      @(posedge sys_clk);
      #1;
    end
    repeat (6) @(posedge sys_clk);
    #1;
    check(sel ? "drain_b" : "drain_a", sel ? exp_q_b.size() : exp_q_a.size(), 0);
  endtask

  task automatic do_reset();
    rx(1'b0, 1'b0, 32'h0, 1'b0);
    rx(1'b1, 1'b0, 32'h0, 1'b0);
    sys_rst = 1'b1;
    repeat (2) @(posedge sys_clk);
    #1;
    sys_rst = 1'b0;
    @(posedge sys_clk);
    #1;
  endtask

  task automatic exp_good_frame();
    for (int i = 0; i < 4; i++) exp_word(1'b0, wd[i], i == 0, i == 3, 1'b0);
    for (int i = 0; i < 4; i++) exp_word(1'b0, wd[i], 1'b0, i == 3, i == 3);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] w;
    rec_a.rec_en = 0; rec_a.rec_data = 0; rec_a.rec_pkt_done = 0;
    rec_b.rec_en = 0; rec_b.rec_data = 0; rec_b.rec_pkt_done = 0;
    pix_a.pix_ready = 1'b1;
    pix_b.pix_ready = 1'b1;

    do_reset();
    check("rst_valid", pix_a.pix_valid, 0);
    check("rst_frame_cnt", frame_cnt_a, 0);
    check("rst_err_cnt", err_cnt_a, 0);
    check("rst_fifo_ovf", fifo_ovf_a, 0);

    // Good frame; the final word carries rec_pkt_done in the same cycle
    exp_good_frame();
    send_line(32'hA5010000, 4, 1'b0);
    send_line(32'hA5000001, 4, 1'b1);
    drain(1'b0);
    check("good_frame_cnt", frame_cnt_a, 1);
    check("good_err_cnt", err_cnt_a, 0);

    // Bad tag, then a clean frame
    do_reset();
    send_line(32'h5A010000, 4, 1'b0);
    drain(1'b0);
    check("badtag_err_cnt", err_cnt_a, 1);
    exp_good_frame();
    send_line(32'hA5010000, 4, 1'b0);
    send_line(32'hA5000001, 4, 1'b0);
    drain(1'b0);
    check("badtag_frame_cnt", frame_cnt_a, 1);
    check("badtag_err_cnt2", err_cnt_a, 1);

    // Line skip: out-of-range line rejected, then continuation rejected because frame dropped
    do_reset();
    for (int i = 0; i < 4; i++) exp_word(1'b0, wd[i], i == 0, i == 3, 1'b0);
    send_line(32'hA5010000, 4, 1'b0);
    send_line(32'hA5000005, 4, 1'b0);
    check("skip_err_cnt", err_cnt_a, 1);
    send_line(32'hA5000001, 4, 1'b0);
    drain(1'b0);
    check("skip_err_cnt2", err_cnt_a, 2);
    check("skip_frame_cnt", frame_cnt_a, 0);

    // Short packet, then surplus packet
    do_reset();
    exp_word(1'b0, wd[0], 1'b1, 1'b0, 1'b0);
    exp_word(1'b0, wd[1], 1'b0, 1'b0, 1'b0);
    send_line(32'hA5010000, 2, 1'b0);
    drain(1'b0);
    check("short_err_cnt", err_cnt_a, 1);
    for (int i = 0; i < 4; i++) exp_word(1'b0, wd[i], i == 0, i == 3, 1'b0);
    send_line(32'hA5010000, 6, 1'b0);
    drain(1'b0);
    check("surplus_err_cnt", err_cnt_a, 1);
    check("surplus_frame_cnt", frame_cnt_a, 0);

    // Overflow on the 16-pixel, depth-4 instance with the sink stalled
    do_reset();
    pix_b.pix_ready = 1'b0;
    rx(1'b1, 1'b1, 32'hA5010000, 1'b0);
    for (int k = 1; k <= 8; k++) begin
      w = {16'hA000 + 16'(2 * k - 1), 16'hA000 + 16'(2 * k)};
      if (k <= 5) exp_word(1'b1, w, k == 1, 1'b0, 1'b0);
      rx(1'b1, 1'b1, w, 1'b0);
    end
    rx(1'b1, 1'b0, 32'h0, 1'b1);
    rx(1'b1, 1'b0, 32'h0, 1'b0);
    check("ovf_flag", fifo_ovf_b, 1);
    check("ovf_err_cnt", err_cnt_b, 1);
    check("ovf_stall_valid", pix_b.pix_valid, 1);
    check("ovf_stall_data", pix_b.pix_data, 32'h0000A001);
    repeat (5) @(posedge sys_clk);
    #1;
    check("ovf_stall_hold", {pix_b.pix_sof, pix_b.pix_data}, 32'h0001A001);
    pix_b.pix_ready = 1'b1;
    drain(1'b1);
    check("ovf_flag_sticky", fifo_ovf_b, 1);
    check("ovf_frame_cnt", frame_cnt_b, 0);

    // Reset mid-packet with a pixel pending, then a full frame
    do_reset();
    pix_a.pix_ready = 1'b0;
    rx(1'b0, 1'b1, 32'hA5010000, 1'b0);
    rx(1'b0, 1'b1, wd[0], 1'b0);
    rx(1'b0, 1'b1, wd[1], 1'b0);
    check("midrst_pre_valid", pix_a.pix_valid, 1);
    sys_rst = 1'b1;
    #1;
    check("midrst_valid", pix_a.pix_valid, 0);
    check("midrst_err_cnt", err_cnt_a, 0);
    check("midrst_frame_cnt", frame_cnt_a, 0);
    rec_a.rec_en = 1'b0;
    repeat (2) @(posedge sys_clk);
    #1;
    sys_rst = 1'b0;
    pix_a.pix_ready = 1'b1;
    repeat (3) @(posedge sys_clk);
    #1;
    check("midrst_post_valid", pix_a.pix_valid, 0);
    exp_good_frame();
    send_line(32'hA5010000, 4, 1'b0);
    send_line(32'hA5000001, 4, 1'b0);
    drain(1'b0);
    check("midrst_frame_cnt2", frame_cnt_a, 1);
    check("midrst_err_cnt2", err_cnt_a, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
